// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin sharing of one APB master port among NUM_REQ requesters
// ports: HCLK, HRESETn (async active-low); requester side req_i/addr_i/we_i/wdata_i in,
// done_o/rdata_o/err_o one-cycle completion out; APB side PADDR/PWDATA/PWRITE/PSEL/PENABLE
// out, PRDATA/PREADY/PSLVERR in
module apb_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ-1:0]            we_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]            done_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          err_o,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  output logic                          PWRITE,
  output logic                          PSEL,
  output logic                          PENABLE,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2;
  logic [1:0] state;
  logic [IW-1:0] last, pick, k;
  logic [CW-1:0] cnt;
  logic timeout;
  assign PSEL = state != IDLE;
  assign PENABLE = state == ACCESS;
  assign timeout = TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES);
  always_comb begin
    pick = last;
    k = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = IW'((int'(last) + i) % NUM_REQ);
      pick = req_i[k] ? k : pick;
    end
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= IDLE;
      last    <= IW'(NUM_REQ - 1);
      cnt     <= '0;
      done_o  <= '0;
      rdata_o <= '0;
      err_o   <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      PWRITE  <= 1'b0;
    end else begin
      done_o  <= '0;
      rdata_o <= '0;
      err_o   <= 1'b0;
      case (state)
        IDLE: if (|req_i && ~|done_o) begin
          last   <= pick;
          PADDR  <= addr_i[pick*ADDR_WIDTH +: ADDR_WIDTH];
          PWDATA <= wdata_i[pick*DATA_WIDTH +: DATA_WIDTH];
          PWRITE <= we_i[pick];
          state  <= SETUP;
        end
        SETUP: begin
          cnt   <= '0;
          state <= ACCESS;
        end
        ACCESS: if (PREADY) begin
          done_o[last] <= 1'b1;
          rdata_o      <= PWRITE ? '0 : PRDATA;
          err_o        <= PSLVERR;
          state        <= IDLE;
        end else if (timeout) begin
          done_o[last] <= 1'b1;
          err_o        <= 1'b1;
          state        <= IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed checks of arbitration, APB sequencing, watchdog and reset
module tb_apb_master_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req, we, done;
  logic [63:0] addr, wdata;
  logic [31:0] rdata, paddr, pwdata, prdata;
  logic err, pwrite, psel, penable, pready, pslverr;
  int total = 0;
  int bad = 0;

  apb_master_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .HCLK(clk), .HRESETn(rst_n), .req_i(req), .addr_i(addr), .we_i(we), .wdata_i(wdata),
    .done_o(done), .rdata_o(rdata), .err_o(err), .PADDR(paddr), .PWDATA(pwdata),
    .PWRITE(pwrite), .PSEL(psel), .PENABLE(penable), .PRDATA(prdata), .PREADY(pready),
    .PSLVERR(pslverr)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({psel, penable, pwrite, err, done} !== 5'b0) begin
      bad++;
      $display("FAIL rst_ctrl got=%b exp=00000", {psel, penable, pwrite, err, done});
    end
    total++;
    if (paddr !== 32'h0 || pwdata !== 32'h0 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL rst_data got=%h/%h/%h exp=0/0/0", paddr, pwdata, rdata);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (psel !== 1'b0) begin
      bad++;
      $display("FAIL rst_idle psel got=%b exp=0", psel);
    end
  endtask

  task automatic test_single_write();
    @(posedge clk); #1;
    req = 2'b01; we = 2'b01; addr[31:0] = 32'h1A10_0004; wdata[31:0] = 32'hDEADBEEF;
    pready = 1'b1;
    @(negedge clk);
    total++;
    if (psel !== 1'b0) begin
      bad++;
      $display("FAIL sw_c0 psel got=%b exp=0", psel);
    end
    @(negedge clk);
    total++;
    if ({psel, penable, pwrite} !== 3'b101 || paddr !== 32'h1A10_0004 || pwdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL sw_setup got=%b %h %h exp=101 1a100004 deadbeef", {psel, penable, pwrite}, paddr, pwdata);
    end
    @(negedge clk);
    total++;
    if ({psel, penable} !== 2'b11 || done !== 2'b00) begin
      bad++;
      $display("FAIL sw_access got=%b done=%b exp=11 done=00", {psel, penable}, done);
    end
    @(negedge clk);
    total++;
    if (done !== 2'b01 || err !== 1'b0 || rdata !== 32'h0 || {psel, penable} !== 2'b00) begin
      bad++;
      $display("FAIL sw_done got=%b %b %h %b exp=01 0 0 00", done, err, rdata, {psel, penable});
    end
    @(posedge clk); #1 req = 2'b00;
    @(negedge clk);
    total++;
    if (done !== 2'b00 || psel !== 1'b0) begin
      bad++;
      $display("FAIL sw_after got=%b %b exp=00 0", done, psel);
    end
  endtask

  task automatic test_read_wait();
    @(posedge clk); #1;
    req = 2'b01; we = 2'b00; addr[31:0] = 32'h0000_0040; pready = 1'b0; prdata = 32'h0000_00A5;
    repeat (5) @(negedge clk);
    total++;
    if ({psel, penable} !== 2'b11 || done !== 2'b00) begin
      bad++;
      $display("FAIL rw_wait got=%b done=%b exp=11 done=00", {psel, penable}, done);
    end
    @(posedge clk); #1 pready = 1'b1;
    @(negedge clk);
    total++;
    if (done !== 2'b00 || penable !== 1'b1) begin
      bad++;
      $display("FAIL rw_ready got=%b %b exp=00 1", done, penable);
    end
    @(negedge clk);
    total++;
    if (done !== 2'b01 || rdata !== 32'hA5 || err !== 1'b0) begin
      bad++;
      $display("FAIL rw_done got=%b %h %b exp=01 a5 0", done, rdata, err);
    end
    @(posedge clk); #1 req = 2'b00; pready = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 2'b00 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL rw_hold got=%b %h exp=00 0", done, rdata);
    end
  endtask

  task automatic test_slverr();
    @(posedge clk); #1;
    req = 2'b10; we = 2'b10; addr[63:32] = 32'h0000_0300; wdata[63:32] = 32'h1234;
    pready = 1'b1; pslverr = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (done !== 2'b10 || err !== 1'b1 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL slverr got=%b %b %h exp=10 1 0", done, err, rdata);
    end
    @(posedge clk); #1 req = 2'b00; pslverr = 1'b0; pready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    @(posedge clk); #1;
    req = 2'b01; we = 2'b00; pready = 1'b0; prdata = 32'hA5;
    repeat (7) @(negedge clk);
    total++;
    if ({psel, penable} !== 2'b11 || done !== 2'b00) begin
      bad++;
      $display("FAIL to_c6 got=%b done=%b exp=11 done=00", {psel, penable}, done);
    end
    @(negedge clk);
    total++;
    if (psel !== 1'b0 || done !== 2'b01 || err !== 1'b1 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL to_abort got=%b %b %b %h exp=0 01 1 0", psel, done, err, rdata);
    end
    @(posedge clk); #1 req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_timeout_boundary();
    @(posedge clk); #1;
    req = 2'b10; we = 2'b00; addr[63:32] = 32'h0000_0500; pready = 1'b0; pslverr = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk); #1 pready = 1'b1;
    @(negedge clk);
    total++;
    if ({psel, penable} !== 2'b11) begin
      bad++;
      $display("FAIL tb_c6 got=%b exp=11", {psel, penable});
    end
    @(negedge clk);
    total++;
    if (done !== 2'b10 || err !== 1'b0 || rdata !== 32'hA5) begin
      bad++;
      $display("FAIL tb_ready_wins got=%b %b %h exp=10 0 a5", done, err, rdata);
    end
    @(posedge clk); #1 req = 2'b00; pready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    req = 2'b01; we = 2'b01; pready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (penable !== 1'b1) begin
      bad++;
      $display("FAIL rm_access got=%b exp=1", penable);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({psel, penable} !== 2'b00) begin
      bad++;
      $display("FAIL rm_async got=%b exp=00", {psel, penable});
    end
    req = 2'b00;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (done !== 2'b00) begin
        bad++;
        $display("FAIL rm_nodone got=%b exp=00", done);
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_done [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    int exp_cyc [4] = '{3, 7, 11, 15};
    logic [31:0] exp_addr [4] = '{32'h100, 32'h200, 32'h100, 32'h200};
    int n = 0;
    int cyc = 0;
    @(posedge clk); #1;
    req = 2'b11; we = 2'b00; addr = {32'h200, 32'h100}; pready = 1'b1; prdata = 32'h5A;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      if (done !== 2'b00) begin
        total++;
        if (done !== exp_done[n] || cyc != exp_cyc[n] || paddr !== exp_addr[n] || rdata !== 32'h5A) begin
          bad++;
          $display("FAIL rr_%0d got=%b@%0d %h %h exp=%b@%0d %h 5a", n, done, cyc, paddr, rdata,
                   exp_done[n], exp_cyc[n], exp_addr[n]);
        end
        n++;
      end
      cyc++;
    end
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL rr_count got=%0d exp=4", n);
    end
    @(posedge clk); #1 req = 2'b00; pready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    test_reset();
    test_single_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
